mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 26 ++
 rtl/mem_access_if.sv | 28 ++
 rtl/mem_access_load_extend.sv | 41 ++++
 rtl/mem_access.sv | 159 +++++++++++++++
 tb/tb_mem_access.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the memory-access pipeline stage.
//   state_e      - two-state FSM encoding (IDLE, WAIT)
//   instructions - decoded instruction as handed over by execute; the eight
//                  load/store flags drive the memory stage, the rest is
//                  carried through untouched to writeback.
package mem_access_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic       lb;
    logic       lh;
    logic       lw;
    logic       lbu;
    logic       lhu;
    logic       sb;
    logic       sh;
    logic       sw;
  } instructions;

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory bus between the memory stage and the memory.
//   mem_req   - request, held until mem_ack
//   mem_we    - 1 = store, 0 = load
//   mem_addr  - word-aligned address
//   mem_wdata - lane-replicated store data
//   mem_wstrb - byte enables (0 for loads)
//   mem_rdata - read word, valid in the mem_ack cycle
//   mem_ack   - one-cycle completion
// master: the memory stage; slave: the memory.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_load_extend.sv
// load_extend: combinational load-data extraction.
//   rdata - word returned by memory
//   addr  - low two bits of the byte address (lane select)
//   instr - decoded instruction selecting width and signedness
//   data  - extended 32-bit load result
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  instructions instr,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // lw and the non-load fields need no decoding: a full word is the default.
  logic unused_fields;
  assign unused_fields = ^{instr.rd, instr.alu_op, instr.lw,
                           instr.sb, instr.sh, instr.sw};

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    if (instr.lb)       data = {{24{byte_sel[7]}}, byte_sel};
    else if (instr.lbu) data = {24'h0, byte_sel};
    else if (instr.lh)  data = {{16{half_sel[15]}}, half_sel};
    else if (instr.lhu) data = {16'h0, half_sel};
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory pipeline stage between execute and writeback.
//   clk, rstn            - clock, asynchronous active-low reset
//   enabled              - accept pulse; samples instr/result/rs2
//   instr, result, rs2   - decoded instruction, ALU result/address, store data
//   completed            - idle with a valid output for writeback
//   instr_out/result_out - registered instruction and result (load data,
//                          ALU pass-through, or 0 for stores/timeouts)
//   misaligned, timeout  - per-operation status, cleared on next accept
//   mem                  - data-memory bus (master side)
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enabled,
  input  instructions  instr,
  input  logic [31:0]  result,
  input  logic [31:0]  rs2,
  output logic         completed,
  output instructions  instr_out,
  output logic [31:0]  result_out,
  output logic         misaligned,
  output logic         timeout,
  mem_access_if.master mem
);

  // The counter only has to hold 0 .. TIMEOUT_CYCLES-1; the last WAIT
  // cycle is recognised by value, so it never needs to wrap.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  instructions       instr_q, instr_d;
  logic [31:0]       result_q, result_d;
  logic              mis_q, mis_d;
  logic              to_q, to_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  logic              is_load, is_store, align_err;
  logic [31:0]       load_data;

  load_extend u_load_extend (
    .rdata (mem.mem_rdata),
    .addr  (addr_q[1:0]),
    .instr (instr_q),
    .data  (load_data)
  );

  // Request is derived from state so an asynchronous reset drops it at once.
  assign mem.mem_req   = (state_q == WAIT);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;

  assign completed  = (state_q == IDLE) && !enabled;
  assign instr_out  = instr_q;
  assign result_out = result_q;
  assign misaligned = mis_q;
  assign timeout    = to_q;

  assign is_load   = instr.lb | instr.lh | instr.lw | instr.lbu | instr.lhu;
  assign is_store  = instr.sb | instr.sh | instr.sw;
  assign align_err = ((instr.lh | instr.lhu | instr.sh) & result[0]) |
                     ((instr.lw | instr.sw) & (result[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      mis_q    <= 1'b0;
      to_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      mis_q    <= mis_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    mis_d    = mis_q;
    to_d     = to_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;

    case (state_q)
      IDLE: begin
        if (enabled) begin
          instr_d = instr;
          mis_d   = 1'b0;
          to_d    = 1'b0;
          if (!(is_load || is_store)) begin
            result_d = result;
          end else if (align_err) begin
            mis_d    = 1'b1;
            result_d = result;
          end else begin
            addr_d  = result;
            we_d    = is_store;
            cnt_d   = '0;
            state_d = WAIT;
            wstrb_d = 4'b0000;
            wdata_d = 32'h0;
            if (instr.sb) begin
              wstrb_d = 4'b0001 << result[1:0];
              wdata_d = {4{rs2[7:0]}};
            end else if (instr.sh) begin
              wstrb_d = 4'b0011 << result[1:0];
              wdata_d = {2{rs2[15:0]}};
            end else if (instr.sw) begin
              wstrb_d = 4'b1111;
              wdata_d = rs2;
            end
          end
        end
      end
      WAIT: begin
        // An ack in the final allowed cycle still completes normally.
        if (mem.mem_ack) begin
          result_d = we_q ? 32'h0 : load_data;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          to_d     = 1'b1;
          result_d = 32'h0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access (TIMEOUT_CYCLES = 4).
// Stimulus pushes expected completions and bus requests into queues; two
// monitors compare on each rising completed and on every mem_req cycle.
module tb_mem_access;
  import mem_access_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        mis;
    logic        to;
    instructions ins;
  } comp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;
  } bus_t;

  logic        clk;
  logic        rstn;
  logic        enabled;
  instructions instr;
  logic [31:0] result;
  logic [31:0] rs2;
  logic        completed;
  instructions instr_out;
  logic [31:0] result_out;
  logic        misaligned;
  logic        timeout;

  mem_access_if bus ();

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enabled    (enabled),
    .instr      (instr),
    .result     (result),
    .rs2        (rs2),
    .completed  (completed),
    .instr_out  (instr_out),
    .result_out (result_out),
    .misaligned (misaligned),
    .timeout    (timeout),
    .mem        (bus)
  );

  int    total = 0;
  int    bad = 0;
  comp_t comp_q[$];
  bus_t  bus_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic instructions mkOp(input string k, input logic [4:0] rd);
    instructions i;
    i = '0;
    i.rd = rd;
    case (k)
      "lb":    i.lb = 1'b1;
      "lh":    i.lh = 1'b1;
      "lw":    i.lw = 1'b1;
      "lbu":   i.lbu = 1'b1;
      "lhu":   i.lhu = 1'b1;
      "sb":    i.sb = 1'b1;
      "sh":    i.sh = 1'b1;
      "sw":    i.sw = 1'b1;
      default: i.alu_op = 4'd3;
    endcase
    return i;
  endfunction

  task automatic expectDone(input logic [31:0] res, input logic mis,
                            input logic to, input instructions ins);
    comp_t c;
    c.res = res; c.mis = mis; c.to = to; c.ins = ins;
    comp_q.push_back(c);
  endtask

  task automatic expectBus(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int len);
    bus_t b;
    b.we = we; b.addr = addr; b.wdata = wdata; b.wstrb = wstrb; b.len = len;
    bus_q.push_back(b);
  endtask

  // One-cycle accept pulse; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input instructions i, input logic [31:0] r,
                               input logic [31:0] d);
    @(posedge clk); #1;
    enabled = 1'b1; instr = i; result = r; rs2 = d;
    @(posedge clk); #1;
    enabled = 1'b0;
  endtask

  // Ack in the n-th WAIT cycle counted from the one already in progress.
  task automatic waitAck(input int n, input logic [31:0] d);
    repeat (n - 1) @(posedge clk);
    #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = d;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  // Completion monitor: each rising completed consumes one expectation.
  initial begin
    logic  prev_comp;
    comp_t e;
    prev_comp = 1'b0;
    forever begin
      @(negedge clk);
      if (completed && !prev_comp) begin
        if (comp_q.size() == 0) begin
          checkOutput("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = comp_q.pop_front();
          checkOutput("result_out", result_out, e.res);
          checkOutput("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
          checkOutput("timeout", {31'h0, timeout}, {31'h0, e.to});
          checkOutput("instr_out", {15'h0, instr_out}, {15'h0, e.ins});
        end
      end
      prev_comp = completed;
    end
  end

  // Bus monitor: every request cycle is compared against the expected
  // request, which also proves the fields stay constant until ack.
  initial begin
    logic prev_req;
    logic have_cur;
    bus_t cur;
    int   len;
    prev_req = 1'b0;
    have_cur = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (!prev_req) begin
          len = 0;
          if (bus_q.size() == 0) begin
            checkOutput("unexpected_req", 32'd1, 32'd0);
            have_cur = 1'b0;
          end else begin
            cur = bus_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          checkOutput("mem_we", {31'h0, bus.mem_we}, {31'h0, cur.we});
          checkOutput("mem_addr", bus.mem_addr, cur.addr);
          checkOutput("mem_wdata", bus.mem_wdata, cur.wdata);
          checkOutput("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, cur.wstrb});
        end
        len++;
      end else if (prev_req && have_cur) begin
        checkOutput("req_cycles", 32'(len), 32'(cur.len));
        have_cur = 1'b0;
      end
      prev_req = bus.mem_req;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0; enabled = 1'b0; instr = '0; result = '0; rs2 = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    expectDone(32'h0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_mem_req", {31'h0, bus.mem_req}, 32'h0);
    checkOutput("reset_mem_we", {31'h0, bus.mem_we}, 32'h0);
    checkOutput("reset_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    checkOutput("reset_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("reset_mem_wdata", bus.mem_wdata, 32'h0);
    rstn = 1'b1;

    $display("[TB] ALU pass-through");
    expectDone(32'h0000_1234, 1'b0, 1'b0, mkOp("alu", 5'd1));
    applyStimulus(mkOp("alu", 5'd1), 32'h0000_1234, 32'h0);

    $display("[TB] lb at 0x103");
    expectBus(1'b0, 32'h100, 32'h0, 4'b0000, 3);
    expectDone(32'hFFFF_FF80, 1'b0, 1'b0, mkOp("lb", 5'd2));
    applyStimulus(mkOp("lb", 5'd2), 32'h0000_0103, 32'h0);
    waitAck(3, 32'h80FF_0000);

    $display("[TB] sh at 0x202");
    expectBus(1'b1, 32'h200, 32'hBEEF_BEEF, 4'b1100, 2);
    expectDone(32'h0, 1'b0, 1'b0, mkOp("sh", 5'd0));
    applyStimulus(mkOp("sh", 5'd0), 32'h0000_0202, 32'hDEAD_BEEF);
    waitAck(2, 32'h0);

    $display("[TB] misaligned lw, then flag clears");
    expectDone(32'h0000_0101, 1'b1, 1'b0, mkOp("lw", 5'd3));
    applyStimulus(mkOp("lw", 5'd3), 32'h0000_0101, 32'h0);
    expectDone(32'h0000_5555, 1'b0, 1'b0, mkOp("alu", 5'd4));
    applyStimulus(mkOp("alu", 5'd4), 32'h0000_5555, 32'h0);

    $display("[TB] lw timeout");
    expectBus(1'b0, 32'h300, 32'h0, 4'b0000, 4);
    expectDone(32'h0, 1'b0, 1'b1, mkOp("lw", 5'd5));
    applyStimulus(mkOp("lw", 5'd5), 32'h0000_0300, 32'h0);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] lhu acked in last allowed cycle");
    expectBus(1'b0, 32'h200, 32'h0, 4'b0000, 4);
    expectDone(32'h0000_8001, 1'b0, 1'b0, mkOp("lhu", 5'd6));
    applyStimulus(mkOp("lhu", 5'd6), 32'h0000_0202, 32'h0);
    waitAck(4, 32'h8001_7FFF);

    $display("[TB] lh immediate ack");
    expectBus(1'b0, 32'h0, 32'h0, 4'b0000, 1);
    expectDone(32'hFFFF_8765, 1'b0, 1'b0, mkOp("lh", 5'd7));
    applyStimulus(mkOp("lh", 5'd7), 32'h0000_0000, 32'h0);
    waitAck(1, 32'h1234_8765);

    $display("[TB] lbu with enabled pulse during WAIT");
    expectBus(1'b0, 32'h0, 32'h0, 4'b0000, 3);
    expectDone(32'h0000_00AB, 1'b0, 1'b0, mkOp("lbu", 5'd8));
    applyStimulus(mkOp("lbu", 5'd8), 32'h0000_0002, 32'h0);
    enabled = 1'b1; instr = mkOp("alu", 5'd9); result = 32'h0000_9999;
    @(posedge clk); #1;
    enabled = 1'b0;
    waitAck(2, 32'h00AB_0000);

    $display("[TB] sb at 0x001");
    expectBus(1'b1, 32'h0, 32'h7878_7878, 4'b0010, 1);
    expectDone(32'h0, 1'b0, 1'b0, mkOp("sb", 5'd0));
    applyStimulus(mkOp("sb", 5'd0), 32'h0000_0001, 32'h1234_5678);
    waitAck(1, 32'h0);

    $display("[TB] reset during sw WAIT");
    expectBus(1'b1, 32'h400, 32'hA5A5_0F0F, 4'b1111, 1);
    expectDone(32'h0, 1'b0, 1'b0, '0);
    applyStimulus(mkOp("sw", 5'd0), 32'h0000_0400, 32'hA5A5_0F0F);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checkOutput("async_mem_req", {31'h0, bus.mem_req}, 32'h0);
    checkOutput("async_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    checkOutput("async_mem_addr", bus.mem_addr, 32'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    checkOutput("post_reset_completed", {31'h0, completed}, 32'h1);
    checkOutput("post_reset_result", result_out, 32'h0);

    $display("[TB] ALU after reset");
    expectDone(32'h0000_CAFE, 1'b0, 1'b0, mkOp("alu", 5'd10));
    applyStimulus(mkOp("alu", 5'd10), 32'h0000_CAFE, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pending_completions", 32'(comp_q.size()), 32'h0);
    checkOutput("pending_requests", 32'(bus_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
